// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - host, multiply-request and ALU signal bundle for alu_mul_sequencer
interface alu_mul_sequencer_if;
    // Multiply request / result
    logic        START;
    logic [7:0]  MCAND;
    logic [7:0]  MPLIER;
    logic        BUSY;
    logic        DONE;
    logic [15:0] PRODUCT;

    // Direct host ALU port
    logic [7:0]  HOST_A;
    logic [7:0]  HOST_B;
    logic [2:0]  HOST_OP;
    logic        HOST_GNT;
    logic [7:0]  HOST_Y;

    // Shared ALU instance
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [2:0]  ALU_OP;
    logic [7:0]  ALU_Y;
    logic        ALU_C;

    // Sequencer side
    modport slave (
        input  START, MCAND, MPLIER,
        input  HOST_A, HOST_B, HOST_OP,
        input  ALU_Y, ALU_C,
        output BUSY, DONE, PRODUCT,
        output HOST_GNT, HOST_Y,
        output ALU_A, ALU_B, ALU_OP
    );

    // Environment side (datapath control plus the ALU itself)
    modport master (
        output START, MCAND, MPLIER,
        output HOST_A, HOST_B, HOST_OP,
        output ALU_Y, ALU_C,
        input  BUSY, DONE, PRODUCT,
        input  HOST_GNT, HOST_Y,
        input  ALU_A, ALU_B, ALU_OP
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shares an 8-bit ALU between the host and a shift-and-add multiplier; optional ALU_MUL_ZERO_SKIP_EN
module alu_mul_sequencer #(
    parameter logic [2:0] OP_ADD = 3'b000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    alu_mul_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  p_hi_q, p_hi_d;
    logic [7:0]  p_lo_q, p_lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        host_gnt;
    logic        zero_operand;

    // A zero operand only changes the flow when the skip feature is built in
`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zero_operand = (bus.MCAND == 8'h00) || (bus.MPLIER == 8'h00);
`else
    assign zero_operand = 1'b0;
`endif

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            m_q     <= 8'h00;
            p_hi_q  <= 8'h00;
            p_lo_q  <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, shift-and-add step and ALU routing
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        cnt_d    = cnt_q;
        host_gnt = 1'b1;
        alu_a    = bus.HOST_A;
        alu_b    = bus.HOST_B;
        alu_op   = bus.HOST_OP;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    m_d    = bus.MCAND;
                    p_hi_d = 8'h00;
                    p_lo_d = bus.MPLIER;
                    cnt_d  = 3'd0;
                    if (zero_operand) begin
                        // Product of a zero operand is known immediately
                        p_lo_d  = 8'h00;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                host_gnt = 1'b0;
                alu_a    = p_hi_q;
                alu_b    = m_q;
                alu_op   = OP_ADD;
                // The add carry becomes the new top bit before the right shift
                if (p_lo_q[0]) begin
                    {p_hi_d, p_lo_d} = {bus.ALU_C, bus.ALU_Y, p_lo_q[7:1]};
                end else begin
                    {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[7:1]};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.ALU_A    = alu_a;
    assign bus.ALU_B    = alu_b;
    assign bus.ALU_OP   = alu_op;
    assign bus.HOST_GNT = host_gnt;
    assign bus.HOST_Y   = bus.ALU_Y;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.PRODUCT  = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - self-checking bench for alu_mul_sequencer with a behavioural ALU and multiply model
module tb_alu_mul_sequencer;

    localparam logic [2:0] OP_ADD = 3'b000;

`ifdef ALU_MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_mul_sequencer_if bus();

    alu_mul_sequencer #(.OP_ADD(OP_ADD)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [8:0] alu_res;
    always_comb begin
        alu_res    = alu_fn(bus.ALU_A, bus.ALU_B, bus.ALU_OP);
        bus.ALU_Y  = alu_res[7:0];
        bus.ALU_C  = alu_res[8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge (cycle 0); returns just after a rising edge
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b, input bit extra);
        int          lat;
        int          k;
        int          done_k;
        int          busy_n;
        int          nogrant_n;
        int          badop_n;
        logic [15:0] exp_p;
        logic [15:0] prod_at_done;

        exp_p = 16'(a) * 16'(b);
        lat   = (SKIP && (a == 8'h00 || b == 8'h00)) ? 1 : 9;
        done_k = 0; busy_n = 0; nogrant_n = 0; badop_n = 0;
        prod_at_done = 16'h0;

        bus.START = 1'b1; bus.MCAND = a; bus.MPLIER = b;
        @(negedge clk);
        chk({tag, "_c0_gnt"}, 32'(bus.HOST_GNT), 32'd1);
        @(posedge clk); #1;
        bus.START = 1'b0;
        k = 1;
        while (done_k == 0 && k <= 20) begin
            if (extra && (k == 4 || k == 9)) begin
                bus.START = 1'b1; bus.MCAND = 8'd3; bus.MPLIER = 8'd3;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
            if (bus.BUSY) busy_n++;
            if (!bus.HOST_GNT) begin
                nogrant_n++;
                if (bus.ALU_OP !== OP_ADD) badop_n++;
            end
            if (bus.DONE === 1'b1) begin
                done_k = k;
                prod_at_done = bus.PRODUCT;
                chk({tag, "_done_gnt"}, 32'(bus.HOST_GNT), 32'd1);
                chk({tag, "_done_busy"}, 32'(bus.BUSY), 32'd0);
            end
            @(posedge clk); #1;
            k++;
        end
        bus.START = 1'b0;
        chk({tag, "_latency"}, 32'(done_k), 32'(lat));
        chk({tag, "_product"}, 32'(prod_at_done), 32'(exp_p));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        chk({tag, "_nogrant_cycles"}, 32'(nogrant_n), 32'(lat - 1));
        chk({tag, "_run_op"}, 32'(badop_n), 32'd0);
        @(negedge clk);
        chk({tag, "_after_done"}, 32'(bus.DONE), 32'd0);
        chk({tag, "_after_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_hold"}, 32'(bus.PRODUCT), 32'(exp_p));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [8:0] exp_alu;
        logic [7:0] ra, rb;
        int         saw_done;

        checks = 0; errors = 0;
        rst = 1'b1;
        bus.START = 1'b0; bus.MCAND = 8'h00; bus.MPLIER = 8'h00;
        bus.HOST_A = 8'h00; bus.HOST_B = 8'h00; bus.HOST_OP = OP_ADD;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and host pass-through
        @(negedge clk);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_product", 32'(bus.PRODUCT), 32'h0);
        chk("rst_gnt", 32'(bus.HOST_GNT), 32'd1);
        bus.HOST_A = 8'h12; bus.HOST_B = 8'h34; bus.HOST_OP = OP_ADD;
        #1;
        chk("host_alu_a", 32'(bus.ALU_A), 32'h12);
        chk("host_alu_b", 32'(bus.ALU_B), 32'h34);
        chk("host_alu_op", 32'(bus.ALU_OP), 32'(OP_ADD));
        chk("host_y", 32'(bus.HOST_Y), 32'h46);

        // Random host traffic while idle
        for (int i = 0; i < 6; i++) begin
            bus.HOST_A = 8'($urandom); bus.HOST_B = 8'($urandom); bus.HOST_OP = 3'($urandom_range(0, 7));
            #1;
            exp_alu = alu_fn(bus.HOST_A, bus.HOST_B, bus.HOST_OP);
            chk("host_rand_a", 32'(bus.ALU_A), 32'(bus.HOST_A));
            chk("host_rand_y", 32'(bus.HOST_Y), 32'(exp_alu[7:0]));
        end
        @(posedge clk); #1;

        // Directed multiplies
        run_mul("m13x11", 8'd13, 8'd11, 1'b0);
        run_mul("mffxff", 8'hFF, 8'hFF, 1'b0);
        run_mul("m00x5a", 8'h00, 8'h5A, 1'b0);

        // START pulses in RUN and DONE are ignored
        run_mul("m_ignore", 8'd200, 8'd77, 1'b1);
        run_mul("m3x3", 8'd3, 8'd3, 1'b0);

        // Random multiplies, host operands also randomised
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if (i == 5) rb = 8'h00;
            bus.HOST_A = 8'($urandom); bus.HOST_B = 8'($urandom); bus.HOST_OP = 3'($urandom_range(0, 7));
            run_mul("m_rand", ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of cycle 5 of a RUN
        bus.START = 1'b1; bus.MCAND = 8'd200; bus.MPLIER = 8'd201;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.BUSY), 32'd0);
        chk("arst_done", 32'(bus.DONE), 32'd0);
        chk("arst_product", 32'(bus.PRODUCT), 32'h0);
        chk("arst_gnt", 32'(bus.HOST_GNT), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) saw_done++;
        end
        chk("arst_no_done", 32'(saw_done), 32'd0);
        @(posedge clk); #1;
        run_mul("m7x6", 8'd7, 8'd6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
